id_ctrl_issue: RTL
==================

// Module: id_ctrl_issue
// PURPOSE
// Decode-stage control generator and issuer: decodes the IF/ID instruction into the
// 17-bit control bundle consumed by the ID/EX pipeline register. Registers the bundle
// (1-cycle latency), detects load-use hazards, inserts bubbles, and squashes on EX flush.
// PARAMETERS
// STALL_CYCLES  1   bubbles inserted per load-use hazard (1..7)
// CNT_W         16  width of saturating stall counter
// PORTS
// clk              in   1   clock, rising edge
// reset_n          in   1   async reset, active low
// instr_valid      in   1   IF/ID holds a valid instruction
// instr            in   32  instruction word (op[31:26] rs[25:21] rt[20:16] rd[15:11] funct[5:0])
// id_ready         out  1   comb; instruction accepted on edge when instr_valid && id_ready
// ex_flush         in   1   branch/jump taken in EX; squash
// control_signals  out  17  registered bundle to ID/EX
// ctrl_valid       out  1   bundle holds a real instruction (0 = bubble)
// dest_reg         out  5   registered destination (rd, rt, or 31 for JAL)
// illegal_instr    out  1   registered; accepted opcode/funct not in table
// stall_cnt        out  CNT_W  saturating count of bubble cycles from hazards
// BEHAVIOUR
// Bundle: [16:14] src_sel(000 reg,001 sext imm,010 zext imm,011 lui) [13:11] alu_op
//  [10] load [9] rf_en [8] branch [7] store [6] mem_en [5:4] size(00 B,10 W) [3] unsigned
//  [2] jump [1] link [0] dest_rt.
// Decode: op0 funct 20/22/24/25/2A -> alu 000/001/010/011/100, rf_en, src 000, dest rd.
//  08 ADDI alu000 src001 rf_en dest_rt; 0D ORI alu011 src010 rf_en dest_rt;
//  0F LUI alu101 src011 rf_en dest_rt; 23 LW load rf_en mem_en size10 src001 dest_rt;
//  24 LBU as LW with size00 unsigned; 2B SW store mem_en size10 src001;
//  04 BEQ branch alu001 src000; 02 J jump; 03 JAL jump link rf_en dest_reg=31.
//  Anything else: bundle 0, ctrl_valid 1, illegal_instr 1.
// Reset (async, reset_n=0): control_signals 0, ctrl_valid 0, dest_reg 0, illegal_instr 0,
//  stall_cnt 0, state RUN, load tracker cleared. Outputs only change on clk edges.
// State RUN: id_ready = !hazard. Accept -> decoded bundle/dest registered next edge,
//  ctrl_valid 1. instr_valid 0 -> bubble (all 0, ctrl_valid 0).
// Hazard (comb): last issued bundle had load=1, its dest_reg != 0, incoming instr_valid,
//  and dest == rs, or dest == rt for R-type/SW/BEQ. On hazard: bubble issued, enter
//  STALL with counter = STALL_CYCLES-1 (STALL_CYCLES=1 -> stay RUN, tracker cleared).
// State STALL: id_ready 0, bubbles issued, counter decrements; at 0 return to RUN.
//  Tracker cleared on first bubble so the same instruction then issues.
// stall_cnt +1 per hazard bubble cycle, saturates at all-ones (no wrap).
// ex_flush (highest priority, same edge): bubble issued, id_ready 0 that cycle,
//  state -> RUN, tracker cleared, illegal_instr 0; instr present is not consumed.
// Bubbles never set illegal_instr. Async reset mid-stall aborts to RUN immediately.
// TESTING
// reset_n=0 with instr_valid=1 -> all outputs 0, id_ready=1 after release.
// ADD (00000020, rd=3) -> next edge control=17'h00200, dest_reg=3, ctrl_valid=1.
// LW rt=5 then ADD rs=5 -> ADD held 1 cycle, bubble, id_ready=0, stall_cnt=1, ADD issues next.
// LW rt=0 then ADD rs=0 -> no stall; STALL_CYCLES=3 -> exactly 3 bubbles, stall_cnt=3.
// ex_flush=1 during STALL -> bubble, RUN next cycle, instr re-presented and issued.
// opcode 3F -> illegal_instr=1, control=0, ctrl_valid=1; stall_cnt forced near max saturates.

Source files
------------

// File: rtl/id_ctrl_issue_if.sv
// id_ctrl_issue_if: IF/ID instruction handshake and ID/EX control bundle
interface id_ctrl_issue_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        id_ready;
    logic        ex_flush;
    logic [16:0] control_signals;
    logic        ctrl_valid;
    logic [4:0]  dest_reg;
    logic        illegal_instr;
    modport master (
        output instr_valid, instr, ex_flush,
        input  id_ready, control_signals, ctrl_valid, dest_reg, illegal_instr
    );
    modport slave (
        input  instr_valid, instr, ex_flush,
        output id_ready, control_signals, ctrl_valid, dest_reg, illegal_instr
    );
endinterface

// File: rtl/id_ctrl_issue.sv
// id_ctrl_issue: decode IF/ID instruction into a registered ID/EX control bundle with load-use stalls and flush
module id_ctrl_issue #(
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    id_ctrl_issue_if.slave   bus,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef struct packed {
        logic [2:0] src;
        logic [2:0] alu;
        logic       load;
        logic       rf_en;
        logic       branch;
        logic       store;
        logic       mem_en;
        logic [1:0] size;
        logic       uns;
        logic       jump;
        logic       link;
        logic       dest_rt;
    } ctrl_t;
    typedef enum logic {RUN, STALL} state_t;
    localparam logic [2:0] EXTRA = 3'(STALL_CYCLES - 1);
    state_t     state;
    logic [2:0] cnt;
    ctrl_t      c;
    logic       ill;
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] dst;
    logic       uses_rt;
    logic       hazard;
    logic       accept;
    logic       hz_bubble;
    logic       unused_shamt;
    assign op           = bus.instr[31:26];
    assign rs           = bus.instr[25:21];
    assign rt           = bus.instr[20:16];
    assign rd           = bus.instr[15:11];
    assign funct        = bus.instr[5:0];
    assign unused_shamt = ^bus.instr[10:6];
    assign dst          = c.rf_en ? (c.link ? 5'd31 : c.dest_rt ? rt : rd) : 5'd0;
    assign uses_rt      = op == 6'h00 || op == 6'h2B || op == 6'h04;
    // the registered bundle is the last issued instruction; a bubble clears it, so it doubles as the load tracker
    assign hazard       = bus.control_signals[10] && bus.dest_reg != 5'd0 && bus.instr_valid &&
                          (bus.dest_reg == rs || (uses_rt && bus.dest_reg == rt));
    assign bus.id_ready = state == RUN && !hazard && !bus.ex_flush;
    assign accept       = bus.instr_valid && bus.id_ready;
    assign hz_bubble    = !bus.ex_flush && (state == STALL || hazard);
    // opcode/funct decode table
    always_comb begin
        c   = '0;
        ill = 1'b0;
        case (op)
            6'h00: begin
                c.rf_en = 1'b1;
                case (funct)
                    6'h20: c.alu = 3'b000;
                    6'h22: c.alu = 3'b001;
                    6'h24: c.alu = 3'b010;
                    6'h25: c.alu = 3'b011;
                    6'h2A: c.alu = 3'b100;
                    default: begin
                        c   = '0;
                        ill = 1'b1;
                    end
                endcase
            end
            6'h08: begin
                c.src = 3'b001; c.rf_en = 1'b1; c.dest_rt = 1'b1;
            end
            6'h0D: begin
                c.src = 3'b010; c.alu = 3'b011; c.rf_en = 1'b1; c.dest_rt = 1'b1;
            end
            6'h0F: begin
                c.src = 3'b011; c.alu = 3'b101; c.rf_en = 1'b1; c.dest_rt = 1'b1;
            end
            6'h23: begin
                c.src = 3'b001; c.load = 1'b1; c.rf_en = 1'b1; c.mem_en = 1'b1;
                c.size = 2'b10; c.dest_rt = 1'b1;
            end
            6'h24: begin
                c.src = 3'b001; c.load = 1'b1; c.rf_en = 1'b1; c.mem_en = 1'b1;
                c.uns = 1'b1; c.dest_rt = 1'b1;
            end
            6'h2B: begin
                c.src = 3'b001; c.store = 1'b1; c.mem_en = 1'b1; c.size = 2'b10;
            end
            6'h04: begin
                c.branch = 1'b1; c.alu = 3'b001;
            end
            6'h02: c.jump = 1'b1;
            6'h03: begin
                c.jump = 1'b1; c.link = 1'b1; c.rf_en = 1'b1;
            end
            default: ill = 1'b1;
        endcase
    end
    // issue FSM: registered bundle, bubble insertion, stall counting and flush squash
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.control_signals <= '0;
            bus.ctrl_valid      <= 1'b0;
            bus.dest_reg        <= '0;
            bus.illegal_instr   <= 1'b0;
            stall_cnt           <= '0;
            state               <= RUN;
            cnt                 <= '0;
        end else begin
            bus.control_signals <= accept ? c : '0;
            bus.ctrl_valid      <= accept;
            bus.dest_reg        <= accept ? dst : 5'd0;
            bus.illegal_instr   <= accept && ill;
            if (hz_bubble && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (bus.ex_flush)
                state <= RUN;
            else if (state == STALL) begin
                cnt <= cnt - 3'd1;
                if (cnt == 3'd1)
                    state <= RUN;
            end else if (hazard && EXTRA != 3'd0) begin
                state <= STALL;
                cnt   <= EXTRA;
            end
        end
    end
endmodule
